mod_updown_counter: RTL
=======================

Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down counter; successor to the fixed 4-bit toggle-flop counter.
- Adds configurable width and modulus, count direction, enable, synchronous clear, parallel load, and wrap or saturate mode.
- Provides a carry/borrow output for cascading and a sticky overflow flag.
- Used as a general event/divider counter and cascaded to build wider or BCD-style chains.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH; violation is a static error.
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable, sampled at rising clk.
- up  input  1  direction; 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear to 0; also clears ovf.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- count  output  WIDTH  registered current count.
- tc  output  1  combinational terminal count / carry-out for cascading.
- wrap  output  1  registered one-cycle pulse on a limit event.
- ovf  output  1  registered sticky flag, set on any limit event.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n = 0): count = 0, wrap = 0, ovf = 0 immediately, independent of clk. Outputs hold these values until the first rising clk after deassertion.
- Registered outputs update on the rising clk edge, one cycle after inputs are sampled. Latency is 1 cycle. tc is the only combinational output.
- Per-edge priority:
  - clear: count = 0, ovf = 0, wrap = 0.
  - else load: count = min(load_val, MODULUS-1). wrap = 0; ovf is unchanged.
  - else en with up = 1:
    - if count == MODULUS-1 (limit event): count = 0 if SATURATE = 0, otherwise holds MODULUS-1.
    - otherwise count + 1.
  - else en with up = 0:
    - if count == 0 (limit event): count = MODULUS-1 if SATURATE = 0, otherwise holds 0.
    - otherwise count - 1.
  - else (en = 0): count holds, wrap = 0.
- Limit event definition: en = 1, no clear, no load, and count is at the limit for the current direction.
  - On a limit event: wrap = 1 for exactly one cycle and ovf = 1.
  - The same applies in saturate mode, where a limit event fires on every enabled cycle while the count is held at the limit.
- tc = en & ~clear & ~load & ((up & count == MODULUS-1) | (~up & count == 0)).
  - tc is high in the same cycle that precedes the limit edge.
  - Intended to drive the en of the next stage in a cascade.
- A direction change while count is at a limit takes effect immediately. Example: count = 0 with up = 1 is not a limit event.
- Arithmetic:
  - Next-state computation is WIDTH+1 bits internally.
  - count never leaves 0..MODULUS-1, including when MODULUS = 2**WIDTH.
  - No X propagation from the load path when load = 0.
- Reset asserted mid-operation: all state clears asynchronously. After deassertion, counting resumes from 0 on the next enabled edge.
- Simultaneous clear and load: clear wins. Simultaneous load and en: load wins, and no wrap occurs.

Decomposition:
- Shared package counter_pkg:
  - Direction constants DIR_UP = 1 and DIR_DOWN = 0.
  - Mode constants MODE_WRAP = 0 and MODE_SAT = 1.
  - A function computing the clog2-based legal WIDTH for a given MODULUS, used in the elaboration check.
- One sub-module, count_next_logic: combinational next-count and limit-detect logic.
  - Inputs: count, up, en, clear, load, load_val.
  - Outputs: next_count, limit_evt.
- The top-level module holds the count, wrap and ovf registers and the tc logic.

Test Plan (WIDTH = 4, MODULUS = 10, SATURATE = 0 unless stated):
- Reset then up-count: rst_n low then high, en = 1, up = 1 for 12 cycles -> count 1,2,…,9,0,1,2. tc = 1 while count = 9. wrap pulses exactly once, in the cycle count = 0. ovf = 1 thereafter.
- Down wrap: load_val = 2 with load, then en = 1, up = 0 -> count 2,1,0,9,8. tc = 1 at count = 0. wrap pulses at count = 9.
- Saturate (SATURATE = 1): up-count from 7 for 5 cycles -> count 8,9,9,9,9. wrap pulses on each held cycle. Flip to up = 0 -> count 8.
- Priority and clamp:
  - load = 1, load_val = 14, en = 1 -> count = 9, no wrap.
  - Then clear = 1 and load = 1 together -> count = 0, ovf = 0.
- Async reset mid-count: assert rst_n low between clock edges at count = 6 -> count = 0, wrap = 0 and ovf = 0 before the next edge. Resume counting from 0.
- Cascade: two instances, with tc of the low stage driving en of the high stage; run 25 enabled cycles from 0 -> {high, low} = {2, 5}.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Smallest counter width able to represent 0..modulus-1.
    function automatic int min_width(input longint modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_updown_counter_count_next_logic.sv
// Combinational next-count and limit-event detection for mod_updown_counter.
// Arithmetic runs one bit wider than the count so MODULUS = 2**WIDTH works
// without overflow in the compare or the increment.
module count_next_logic
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             limit_evt
);

    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ZERO  = '0;
    localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);

    logic [WIDTH:0] cur;
    logic [WIDTH:0] ld;
    logic [WIDTH:0] nxt;
    logic           unused_nxt_msb;

    // Priority: clear, then load (clamped), then enabled count with limit handling.
    always_comb begin
        // NOTE: every output gets a default before the if-chain; a path that
        // leaves a variable unassigned would infer a latch.
        cur       = {1'b0, count};
        ld        = {1'b0, load_val};
        nxt       = cur;
        limit_evt = 1'b0;
        if (clear) begin
            nxt = ZERO;
        end else if (load) begin
            nxt = (ld > LIMIT) ? LIMIT : ld;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (cur == LIMIT) begin
                    limit_evt = 1'b1;
                    nxt       = (SATURATE == MODE_SAT) ? LIMIT : ZERO;
                end else begin
                    nxt = cur + ONE;
                end
            end else begin
                if (cur == ZERO) begin
                    limit_evt = 1'b1;
                    nxt       = (SATURATE == MODE_SAT) ? ZERO : LIMIT;
                end else begin
                    nxt = cur - ONE;
                end
            end
        end
        next_count = nxt[WIDTH-1:0];
    end

    // The extra bit only guards the arithmetic; the result always fits WIDTH.
    assign unused_nxt_msb = nxt[WIDTH];

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with load, clear, wrap/saturate mode,
// cascade carry (tc), one-cycle limit pulse (wrap) and sticky overflow (ovf).
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // Reject illegal parameter combinations at elaboration.
    generate
        if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || WIDTH < min_width(MODULUS))
        begin : g_bad_params
            $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic [WIDTH-1:0] next_count;
    logic             limit_evt;

    count_next_logic #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .up         (up),
        .en         (en),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .next_count (next_count),
        .limit_evt  (limit_evt)
    );

    // tc is exactly the limit condition: enabled, not overridden, at the limit.
    assign tc = limit_evt;

    // Count, wrap pulse and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= limit_evt;
            if (clear) begin
                ovf <= 1'b0;
            end else if (limit_evt) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
